hwpe_ctrl_job_sched: RTL

HWPE_CTRL_JOB_SCHED -- requirements
Module: hwpe_ctrl_job_sched

---
 rtl/hwpe_ctrl_job_sched_if.sv | 13 +
 rtl/hwpe_ctrl_job_sched.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/hwpe_ctrl_job_sched_if.sv
// Configuration access bus for the HWPE job scheduler: single-cycle,
// always-granted register reads/writes tagged with a requester ID.
interface hwpe_ctrl_job_sched_if #(
    parameter int ID_WIDTH = 16
);
    logic                req;
    logic                we;
    logic [7:0]          addr;
    logic [ID_WIDTH-1:0] src;

    modport master (output req, we, addr, src);
    modport slave  (input  req, we, addr, src);
endinterface

// File: rtl/hwpe_ctrl_job_sched.sv
// HWPE job scheduler: lock-protected job submission into N_CONTEXT contexts and an
// engine start/run/done sequencer. Define HWPE_CTRL_JOB_SCHED_EVT_EN to build the evt_o pulse.
module hwpe_ctrl_job_sched #(
    parameter  int N_CONTEXT = 2,
    parameter  int ID_WIDTH  = 16,
    localparam int CW        = (N_CONTEXT > 1) ? $clog2(N_CONTEXT) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          clear_i,
    hwpe_ctrl_job_sched_if.slave          cfg,
    input  logic                          done_i,
    output logic                          is_read_o,
    output logic                          is_testset_o,
    output logic                          is_trigger_o,
    output logic                          is_mandatory_o,
    output logic                          is_contexted_o,
    output logic                          is_critical_o,
    output logic                          full_context_o,
    output logic                          true_done_o,
    output logic [CW-1:0]                 pointer_context_o,
    output logic [CW-1:0]                 running_context_o,
    output logic                          start_o,
    output logic                          busy_o,
    output logic                          evt_o
);

    localparam int          CNT_W    = $clog2(N_CONTEXT + 1);
    localparam logic [CW-1:0]    PTR_LAST = CW'(N_CONTEXT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(N_CONTEXT);

    typedef enum logic [1:0] {
        IDLE,
        START,
        RUN,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic                lock_valid_q;
    logic [ID_WIDTH-1:0] lock_src_q;
    logic [4:0]          reg_idx;
    logic                lock_acquire;
    logic                unused_ctx;

    function automatic logic [CW-1:0] wrap_inc(input logic [CW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // The context field of the address is not needed for decoding here.
    assign unused_ctx = ^cfg.addr[7:5];
    assign reg_idx    = cfg.addr[4:0];

    always_comb begin
        is_read_o      = cfg.req & ~cfg.we;
        is_mandatory_o = cfg.req & (reg_idx < 5'd4);
        is_testset_o   = is_read_o & (reg_idx == 5'd1);
        is_contexted_o = cfg.req & (reg_idx >= 5'd8);
        is_trigger_o   = cfg.req & cfg.we & (reg_idx == 5'd0)
                         & lock_valid_q & (lock_src_q == cfg.src);
        is_critical_o  = is_testset_o & lock_valid_q & (lock_src_q != cfg.src);
        full_context_o = (cnt_q == CNT_MAX);
        lock_acquire   = is_testset_o & ~full_context_o & ~lock_valid_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_valid_q <= 1'b0;
            lock_src_q   <= '0;
        end else if (clear_i) begin
            lock_valid_q <= 1'b0;
            lock_src_q   <= '0;
        end else if (is_trigger_o) begin
            lock_valid_q <= 1'b0;
        end else if (lock_acquire) begin
            lock_valid_q <= 1'b1;
            lock_src_q   <= cfg.src;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Clear forces IDLE and suppresses the pulses of the cycle it is seen in.
    always_comb begin
        state_d     = state_q;
        start_o     = 1'b0;
        true_done_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cnt_q != '0) state_d = START;
            end
            START: begin
                start_o = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                if (done_i) state_d = DONE;
            end
            DONE: begin
                true_done_o = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (clear_i) begin
            state_d     = IDLE;
            start_o     = 1'b0;
            true_done_o = 1'b0;
        end
    end

    // A trigger and a retirement in the same cycle cancel out in the count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q             <= '0;
            pointer_context_o <= '0;
            running_context_o <= '0;
        end else if (clear_i) begin
            cnt_q             <= '0;
            pointer_context_o <= '0;
            running_context_o <= '0;
        end else begin
            unique case ({is_trigger_o, true_done_o})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
            if (is_trigger_o) pointer_context_o <= wrap_inc(pointer_context_o);
            if (true_done_o)  running_context_o <= wrap_inc(running_context_o);
        end
    end

    assign busy_o = (cnt_q != '0) | (state_q != IDLE);

`ifdef HWPE_CTRL_JOB_SCHED_EVT_EN
    logic evt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            evt_q <= 1'b0;
        end else if (clear_i) begin
            evt_q <= 1'b0;
        end else begin
            evt_q <= true_done_o;
        end
    end

    assign evt_o = evt_q;
`else
    assign evt_o = 1'b0;
`endif

endmodule
